svc_rv_io_uart_tx: RTL and testbench
====================================

Name: svc_rv_io_uart_tx

Overview:
- Memory-mapped 8N1 UART transmitter attached to the RV SoC io_* bus, directly downstream of the SoC's I/O port.
- Lets firmware running on the single-stage SRAM SoC emit text, e.g. Fibonacci results and cycle/instret counts.
- Contains a small byte FIFO, a programmable baud divisor and a bit-serialiser FSM.

Parameters:
- XLEN, 32, bus data width.
- FIFO_DEPTH, 4, TX FIFO entries (power of 2, >= 2).
- DIV_RESET, 16'd868, divisor value after reset (100 MHz / 115200).

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- io_raddr  input  XLEN  read byte address; only bits [3:2] decoded.
- io_rdata  output  XLEN  read data, combinational from io_raddr.
- io_wen  input  1  write strobe, one cycle per store.
- io_waddr  input  XLEN  write byte address; only bits [3:2] decoded.
- io_wdata  input  XLEN  write data.
- io_wstrb  input  XLEN/8  byte enables.
- txd  output  1  serial out, idle high.
- tx_busy  output  1  high while a frame is shifting or the FIFO is non-empty.

Behaviour:
- Register map (addr[3:2]):
  - 0 TXDATA: write-only; push wdata[7:0] if wstrb[0]. Reads return 0.
  - 1 STATUS: read-only. bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky). Writing any value with wstrb[0] clears overflow.
  - 2 DIV: R/W, 16 bits. wstrb[0] writes [7:0], wstrb[1] writes [15:8]. Reads zero-extend.
  - 3: reserved; reads 0, writes ignored.
- Reset values: txd=1, tx_busy=0, FIFO empty, overflow=0, DIV=DIV_RESET, FSM=IDLE, baud counter=0. io_rdata then decodes reset state (STATUS reads 0x2).
- Push accepted if count<FIFO_DEPTH, or if a pop occurs the same cycle. Otherwise the byte is dropped and overflow set.
- FIFO: circular, pointers wrap modulo FIFO_DEPTH, count width clog2(FIFO_DEPTH)+1.
- Effective divisor: eff = (DIV==0) ? 1 : DIV. Each bit lasts exactly eff clk cycles.
- FSM:
  - IDLE: if FIFO non-empty, pop into shift reg, txd<=0, load counter eff-1 -> START. This is the pop cycle.
  - START: at counter 0, drive bit0, reload, bit index 0 -> DATA.
  - DATA: at counter 0, if index==7, txd<=1 -> STOP; else shift, drive next LSB-first bit, index++.
  - STOP: at counter 0 -> IDLE. Back-to-back bytes: the next start bit begins the cycle after STOP ends. Frame = 10*eff cycles, plus 1 IDLE cycle between frames.
  - Counter decrements in non-IDLE states and reloads eff-1 at every bit boundary.
- A DIV write mid-frame takes effect at the next bit boundary; the current bit keeps its old length.
- txd is registered; first start-bit edge appears 1 cycle after the push when IDLE and the FIFO was empty.
- tx_busy = (FSM!=IDLE) | !empty, registered-equivalent (derived from registered state only).
- Reset mid-frame: txd returns to 1 the next cycle, FIFO flushed, DIV restored to DIV_RESET.

Test Plan:
- Reset, then read STATUS (addr 0x4) -> 0x2. Read DIV (0x8) -> 868. txd=1.
- DIV=4, push 0x55 -> txd low 4 cycles, then 1,0,1,0,1,0,1,0 LSB-first each 4 cycles, then high 4 cycles. Frame 40 cycles; tx_busy drops after stop bit.
- DIV=2, push 6 bytes back-to-back (0x01..0x06) with FIFO_DEPTH=4:
  - Bytes 1–5 accepted (one popped immediately); byte 6 dropped; STATUS bit3=1.
  - Wire shows 0x01..0x05 in order. Write STATUS clears bit3.
- DIV=0 -> bit time 1 cycle. Push 0xA3 -> 10-cycle frame with correct bits.
- Mid-frame, write DIV from 8 to 3 with wstrb=0x1 only -> current bit stays 8 cycles, following bits 3 cycles. DIV reads 3.
- Assert rst during DATA of byte 0x7E with 2 bytes queued -> txd=1 next cycle, STATUS=0x2, nothing further transmitted.

Source files
------------

// File: rtl/svc_rv_io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, programmable baud divisor, bit serialiser.
// Start bit leaves 1 cycle after a push into an idle, empty FIFO; pushes into a full FIFO drop and set sticky overflow.
module svc_rv_io_uart_tx #(
    parameter int          XLEN       = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   io_raddr,
    output logic [XLEN-1:0]   io_rdata,
    input  logic              io_wen,
    input  logic [XLEN-1:0]   io_waddr,
    input  logic [XLEN-1:0]   io_wdata,
    input  logic [XLEN/8-1:0] io_wstrb,
    output logic              txd,
    output logic              tx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [15:0]   cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          txd_q, txd_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   div;

    logic          full, empty, push_req, push_ok, pop, ovf_clr;
    logic          div_wr;
    logic [15:0]   eff_m1;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push_req = io_wen && (io_waddr[3:2] == 2'd0) && io_wstrb[0];
    assign pop      = (state == IDLE) && !empty;
    assign push_ok  = push_req && (!full || pop);
    assign ovf_clr  = io_wen && (io_waddr[3:2] == 2'd1) && io_wstrb[0];
    assign div_wr   = io_wen && (io_waddr[3:2] == 2'd2);
    // A divisor of zero behaves as one cycle per bit.
    assign eff_m1   = (div == 16'd0) ? 16'd0 : div - 16'd1;

    assign txd     = txd_q;
    assign tx_busy = (state != IDLE) || !empty;

    logic unused_bits;
    assign unused_bits = ^{io_raddr[XLEN-1:4], io_raddr[1:0], io_waddr[XLEN-1:4],
                           io_waddr[1:0], io_wdata[XLEN-1:16], io_wstrb[XLEN/8-1:2]};

    always_comb begin
        io_rdata = '0;
        case (io_raddr[3:2])
            2'd1:    io_rdata[3:0]  = {overflow, (state != IDLE), empty, full};
            2'd2:    io_rdata[15:0] = div;
            default: io_rdata = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        txd_n   = txd_q;
        case (state)
            IDLE: begin
                if (!empty) begin
                    sh_n    = mem[rptr];
                    txd_n   = 1'b0;
                    cnt_n   = eff_m1;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == 16'd0) begin
                    txd_n   = sh[0];
                    cnt_n   = eff_m1;
                    idx_n   = 3'd0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    cnt_n = eff_m1;
                    if (idx == 3'd7) begin
                        txd_n   = 1'b1;
                        state_n = STOP;
                    end else begin
                        sh_n  = {1'b0, sh[7:1]};
                        txd_n = sh[1];
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt == 16'd0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            idx      <= 3'd0;
            sh       <= 8'd0;
            txd_q    <= 1'b1;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            div      <= DIV_RESET;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
            txd_q <= txd_n;
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop)     rptr <= rptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (ovf_clr)         overflow <= 1'b0;
            if (div_wr && io_wstrb[0]) div[7:0]  <= io_wdata[7:0];
            if (div_wr && io_wstrb[1]) div[15:8] <= io_wdata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= io_wdata[7:0];
    end
endmodule

// File: tb/tb_svc_rv_io_uart_tx.sv
// Bench for svc_rv_io_uart_tx: register vector table, then frame-decoding scoreboard sequences.
module tb_svc_rv_io_uart_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] io_raddr = '0;
    logic [31:0] io_rdata;
    logic        io_wen = 1'b0;
    logic [31:0] io_waddr = '0;
    logic [31:0] io_wdata = '0;
    logic [3:0]  io_wstrb = '0;
    logic        txd;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];

    svc_rv_io_uart_tx #(.XLEN(32), .FIFO_DEPTH(4), .DIV_RESET(16'd868)) dut (
        .clk(clk), .rst(rst), .io_raddr(io_raddr), .io_rdata(io_rdata),
        .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
        .txd(txd), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All driving tasks start and end at posedge+1.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        io_wen = 1'b1; io_waddr = a; io_wdata = d; io_wstrb = s;
        @(posedge clk); #1;
        io_wen = 1'b0; io_wstrb = '0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        io_raddr = a;
        #1;
        chk(name, io_rdata, exp);
    endtask

    task automatic push_tx(input logic [7:0] b, input bit accept);
        if (accept) exp_q.push_back(b);
        wr(32'h0, {24'h0, b}, 4'h1);
    endtask

    // Decodes one frame; every sample inside a bit must equal the bit's first sample.
    task automatic rx_frame(input int len0, input int lenr, output logic [7:0] b,
                            output int t0, output bit ok);
        int waitc = 0;
        logic [9:0] bits;
        bit bad = 0;
        ok = 0; b = 'x; t0 = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (txd !== 1'b0 && waitc < 5000);
        if (txd !== 1'b0) begin
            chk("rx_start_timeout", 32'(txd), 32'h0);
            return;
        end
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            int len = (i == 0) ? len0 : lenr;
            if (i != 0) @(negedge clk);
            bits[i] = txd;
            for (int k = 1; k < len; k++) begin
                @(negedge clk);
                if (txd !== bits[i]) bad = 1;
            end
        end
        chk("frame_shape", {29'h0, bad, bits[0], bits[9]}, 32'h1);
        b = bits[8:1];
        ok = 1;
    endtask

    task automatic rx_check(input int len0, input int lenr, output int t0);
        logic [7:0] b;
        bit ok;
        logic [7:0] e;
        rx_frame(len0, lenr, b, t0, ok);
        if (ok) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", {24'h0, b}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("rx_byte", {24'h0, b}, {24'h0, e});
            end
        end
    endtask

    typedef struct {
        bit          wen;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int t, tprev, seen;
        vecs[0] = '{0, 32'h0,  32'h0,         4'h0, 32'h4,  32'h2};
        vecs[1] = '{0, 32'h0,  32'h0,         4'h0, 32'h8,  32'd868};
        vecs[2] = '{0, 32'h0,  32'h0,         4'h0, 32'h0,  32'h0};
        vecs[3] = '{0, 32'h0,  32'h0,         4'h0, 32'hC,  32'h0};
        vecs[4] = '{0, 32'h0,  32'h0,         4'h0, 32'h18, 32'd868};
        vecs[5] = '{1, 32'h8,  32'h0000_1234, 4'h3, 32'h8,  32'h1234};
        vecs[6] = '{1, 32'h8,  32'hFFFF_AB56, 4'h1, 32'h8,  32'h1256};
        vecs[7] = '{1, 32'h8,  32'h0000_7700, 4'h2, 32'h8,  32'h7756};
        vecs[8] = '{1, 32'hC,  32'hFFFF_FFFF, 4'hF, 32'hC,  32'h0};
        vecs[9] = '{1, 32'h8,  32'hFFFF_0364, 4'hF, 32'h8,  32'h364};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_txd", 32'(txd), 32'h1);
        chk("reset_busy", 32'(tx_busy), 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wen) wr(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
            rd_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end
        rd_chk("status_after_vecs", 32'h4, 32'h2);

        // 0x55 at divisor 4
        wr(32'h8, 32'h4, 4'h3);
        push_tx(8'h55, 1);
        rx_check(4, 4, t);
        @(negedge clk);
        chk("busy_after_stop", 32'(tx_busy), 32'h0);
        @(posedge clk); #1;

        // Overflow with 6 back-to-back pushes at divisor 2
        wr(32'h8, 32'h2, 4'h3);
        fork
            begin
                for (int i = 1; i <= 6; i++) push_tx(8'(i), i <= 5);
                rd_chk("status_full_ovf", 32'h4, 32'hD);
            end
            begin
                tprev = 0;
                for (int i = 0; i < 5; i++) begin
                    rx_check(2, 2, t);
                    if (i > 0) chk("frame_gap", 32'(t - tprev), 32'd21);
                    tprev = t;
                end
            end
        join
        @(posedge clk); #1;
        repeat (4) @(posedge clk); #1;
        rd_chk("status_ovf_idle", 32'h4, 32'hA);
        wr(32'h4, 32'hFF, 4'h2);
        rd_chk("ovf_kept_no_strb0", 32'h4, 32'hA);
        wr(32'h4, 32'h0, 4'h1);
        rd_chk("ovf_cleared", 32'h4, 32'h2);

        // Divisor 0 acts as 1 cycle per bit
        wr(32'h8, 32'h0, 4'h3);
        push_tx(8'hA3, 1);
        rx_check(1, 1, t);
        @(posedge clk); #1;

        // Mid-frame divisor change 8 -> 3, low byte only
        wr(32'h8, 32'h8, 4'h3);
        push_tx(8'hC5, 1);
        fork
            rx_check(8, 3, t);
            begin
                repeat (4) @(posedge clk);
                #1;
                wr(32'h8, 32'hFFFF_FF03, 4'h1);
                rd_chk("div_mid", 32'h8, 32'h3);
                rd_chk("status_mid", 32'h4, 32'h6);
            end
        join
        repeat (4) @(posedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        // Reset during DATA of 0x7E with two bytes queued
        wr(32'h8, 32'h4, 4'h3);
        push_tx(8'h7E, 1);
        push_tx(8'h11, 1);
        push_tx(8'h22, 1);
        seen = 0;
        while (txd !== 1'b0 && seen < 100) begin
            @(posedge clk); #1;
            seen++;
        end
        chk("rst_seq_start", 32'(txd), 32'h0);
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        chk("rst_mid_txd", 32'(txd), 32'h1);
        chk("rst_mid_busy", 32'(tx_busy), 32'h0);
        rd_chk("rst_mid_status", 32'h4, 32'h2);
        rd_chk("rst_mid_div", 32'h8, 32'd868);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) seen++;
        end
        chk("no_tx_after_rst", 32'(seen), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
